ro_freq_meter: RTL and testbench
================================

Name: ro_freq_meter

Overview:
- Downstream consumer of the ring oscillator stage in the test-pattern power-consumption path.
- Drives the oscillator's enable and counts rising edges of its free-running output over a fixed window of system-clock cycles.
- Produces a saturating edge count used as an on-chip activity/power proxy.
- Measurements are software- or controller-triggered; one measurement per start request.

Parameters:
- WINDOW_CYCLES, 1024, number of clk cycles in the counting window (>=1)
- SETTLE_CYCLES, 16, clk cycles the oscillator runs before counting starts (>=1)
- CNT_W, 16, width of the edge counter/result
- SYNC_STAGES, 2, flip-flop stages synchronising RO_out into clk domain (>=2)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a measurement; sampled only in IDLE or DONE
- RO_out  input  1  asynchronous ring-oscillator output
- ro_enable  output  1  drives the oscillator enable input
- busy  output  1  high in SETTLE and COUNT
- done  output  1  high in DONE; count/overflow valid
- count  output  CNT_W  rising edges of RO_out seen in the window
- overflow  output  1  edge count exceeded 2^CNT_W-1

Behaviour:
- One clock, clk; reset is synchronous and active-high, named reset.
- Reset values: ro_enable=0, busy=0, done=0, count=0, overflow=0, FSM=IDLE, sync chain and edge detector=0.
- RO_out passes through SYNC_STAGES flops, then a 1-flop edge detector; a rising edge is sync_last & ~edge_prev.
- Measurable frequency is limited to below f_clk/2; higher frequencies alias (documented limitation, not detected).
- FSM states: IDLE, SETTLE, COUNT, DONE.
- IDLE: ro_enable=0. start=1 -> SETTLE next cycle; count and overflow cleared on that edge.
- SETTLE: ro_enable=1, busy=1. Runs exactly SETTLE_CYCLES cycles, then -> COUNT. Edges are ignored.
- COUNT: ro_enable=1, busy=1. Runs exactly WINDOW_CYCLES cycles. Each cycle with a detected rising edge increments count. At 2^CNT_W-1, count holds and overflow sets sticky. Then -> DONE.
- DONE: ro_enable=0, done=1. count and overflow hold until the next accepted start. start=1 -> SETTLE with count/overflow cleared; done drops the same edge.
- start while busy is ignored, not queued.
- Latency: start sampled at edge N gives busy=1 from N+1 and done=1 from N+1+SETTLE_CYCLES+WINDOW_CYCLES.
- The window/settle cycle counter is ceil(log2(max(WINDOW_CYCLES,SETTLE_CYCLES)+1)) bits. It reloads on each state entry.
- Reset mid-measurement: next cycle all outputs at reset values, FSM=IDLE, partial count discarded.
- Reset and start in the same cycle: reset wins.
- Edge detector and sync chain keep running in all states. Stale edges from before COUNT are never counted.
- RO_out stuck at either level during COUNT -> count=0, overflow=0, normal DONE.

Optional Feature:
- Macro RO_AUTO_REPEAT_EN.
- Defined: DONE lasts exactly one cycle (done pulse), then the block re-enters SETTLE automatically, clearing count/overflow. count/overflow are also latched into a result register on DONE entry, so count/overflow outputs hold the last completed result during the next measurement. start is needed only to leave IDLE. Back-to-back measurements continue until reset.
- Not defined: behaviour as above. DONE is held until start, and count/overflow are the live registers.

Test Plan:
- Reset, then start pulse with RO model toggling every 4 clk (period 8), WINDOW_CYCLES=1024, SETTLE_CYCLES=16 -> busy from next cycle, done exactly 1041 cycles after start edge, count=128 +/-1, overflow=0, ro_enable low in DONE.
- CNT_W=4, RO period 4 clk, WINDOW_CYCLES=1024 -> count=15, overflow=1, count does not wrap.
- RO_out held at 1 for the whole measurement -> done asserted on schedule, count=0, overflow=0.
- start re-pulsed at cycle 100 of COUNT -> ignored; done timing and count identical to the first test.
- reset asserted at cycle 500 of COUNT -> next cycle ro_enable=0, busy=0, done=0, count=0. A subsequent start yields a full correct measurement (count=128 +/-1).
- With RO_AUTO_REPEAT_EN, one start, RO period 8 -> done pulses of width 1 every 1041 cycles, count updates to 128 +/-1 at each pulse and holds between pulses.

Source files
------------

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronised RO rising edges over a fixed window.
// Optional RO_AUTO_REPEAT_EN: back-to-back measurements with a latched result register.
module ro_freq_meter #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             RO_out,
  output logic             ro_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int MAXC = (WINDOW_CYCLES > SETTLE_CYCLES) ?
                        WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WIN_LD = CW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE, SETTLE, COUNT, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cyc_q, cyc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sync_q  <= '0;
      edge_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], RO_out};
      edge_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          cyc_d   = SET_LD;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      SETTLE: begin
        if (cyc_q == '0) begin
          state_d = COUNT;
          cyc_d   = WIN_LD;
        end else begin
          cyc_d = cyc_q - CW'(1);
        end
      end
      COUNT: begin
        if (rise) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
        if (cyc_q == '0) state_d = DONE;
        else             cyc_d   = cyc_q - CW'(1);
      end
      DONE: begin
`ifdef RO_AUTO_REPEAT_EN
        state_d = SETTLE;
        cyc_d   = SET_LD;
        cnt_d   = '0;
        ovf_d   = 1'b0;
`else
        if (start) begin
          state_d = SETTLE;
          cyc_d   = SET_LD;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == SETTLE) | (state_q == COUNT);
  assign ro_enable = busy;
  assign done      = (state_q == DONE);

`ifdef RO_AUTO_REPEAT_EN
  // Result register keeps the previous measurement visible while the next runs.
  logic [CNT_W-1:0] res_cnt_q;
  logic             res_ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else if (state_q == COUNT && state_d == DONE) begin
      res_cnt_q <= cnt_d;
      res_ovf_q <= ovf_d;
    end
  end

  assign count    = res_cnt_q;
  assign overflow = res_ovf_q;
`else
  assign count    = cnt_q;
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_ro_freq_meter.sv
// Self-checking bench for ro_freq_meter with an edge-window reference model.
// Runs the auto-repeat scenario when RO_AUTO_REPEAT_EN is defined.
module tb_ro_freq_meter;

  localparam int W = 1024;
  localparam int S = 16;
  localparam int LAT = S + W + 1;

  logic        clk = 1'b0;
  logic        reset, start, ro;
  logic        ro_en, busy, done, ovf;
  logic [15:0] cnt;
  logic        ro_en_s, busy_s, done_s, ovf_s;
  logic [3:0]  cnt_s;

  int nerr = 0, nchk = 0;
  int nidx = 0, hp = 0, ph = 0;
  int win_lo = 0, win_hi = -1, exp_cnt = 0;

  always #5 clk = ~clk;

  ro_freq_meter #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(16))
  dut (
    .clk(clk), .reset(reset), .start(start), .RO_out(ro),
    .ro_enable(ro_en), .busy(busy), .done(done),
    .count(cnt), .overflow(ovf)
  );

  ro_freq_meter #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(4))
  dut_s (
    .clk(clk), .reset(reset), .start(start), .RO_out(ro),
    .ro_enable(ro_en_s), .busy(busy_s), .done(done_s),
    .count(cnt_s), .overflow(ovf_s)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(string tag, int obs, int exp);
    nchk++;
    assert ((obs >= exp - 1 && obs <= exp + 1) === 1'b1) else begin
      nerr++;
      $error("FAIL %s: got %0d want %0d+/-1", tag, obs, exp);
    end
  endtask

  // One clock; RO toggles on the falling edge, model counts rises in window.
  task automatic step();
    @(negedge clk);
    nidx++;
    if (hp != 0) begin
      ph++;
      if (ph >= hp) begin
        ph = 0;
        ro = ~ro;
        if (ro && nidx >= win_lo && nidx <= win_hi) exp_cnt++;
      end
    end
  endtask

  task automatic set_window(int n0);
    win_lo  = n0 + S + 1;
    win_hi  = n0 + S + W;
    exp_cnt = 0;
  endtask

  task automatic measure(string tag, int repulse);
    int n0, lat;
    bit seen;
    start = 1'b1;
    n0 = nidx;
    set_window(n0);
    step();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_roen"}, ro_en, 1);
    check({tag, "_done0"}, done, 0);
    seen = 0;
    lat = -1;
    for (int i = 0; i < LAT + 200 && !seen; i++) begin
      start = (repulse > 0 && nidx == n0 + S + repulse);
      step();
      if (done) begin
        seen = 1;
        lat = nidx - n0;
      end
    end
    start = 1'b0;
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_roen_done"}, ro_en, 0);
    check({tag, "_busy_done"}, busy, 0);
    if (hp == 0) check({tag, "_cnt"}, cnt, 0);
    else         check_near({tag, "_cnt"}, int'(cnt), exp_cnt);
    check({tag, "_ovf"}, ovf, 0);
    if (exp_cnt > 16) begin
      check({tag, "_scnt"}, cnt_s, 15);
      check({tag, "_sovf"}, ovf_s, 1);
    end else if (exp_cnt == 0) begin
      check({tag, "_scnt"}, cnt_s, 0);
      check({tag, "_sovf"}, ovf_s, 0);
    end
`ifndef RO_AUTO_REPEAT_EN
    repeat (5) step();
    check({tag, "_hold_done"}, done, 1);
    if (hp != 0) check_near({tag, "_hold_cnt"}, int'(cnt), exp_cnt);
`endif
  endtask

  initial begin
    int n0, prev, lat;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    ro    = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_roen", ro_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cnt, 0);
    check("rst_ovf", ovf, 0);
    hp = 4;
`ifdef RO_AUTO_REPEAT_EN
    start = 1'b1;
    n0 = nidx;
    set_window(n0);
    step();
    start = 1'b0;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      seen = 0;
      lat = -1;
      for (int i = 0; i < LAT + 200 && !seen; i++) begin
        step();
        if (done) begin
          seen = 1;
          lat = nidx - n0;
        end
      end
      check("ar_lat", lat, LAT);
      check_near("ar_cnt", int'(cnt), exp_cnt);
      check("ar_ovf", ovf, 0);
      prev = exp_cnt;
      n0 = nidx;
      set_window(n0);
      step();
      check("ar_pulse", done, 0);
      check("ar_busy", busy, 1);
      repeat (500) step();
      check_near("ar_hold", int'(cnt), prev);
    end
`else
    measure("p8", 0);
    hp = 2;
    measure("p4", 0);
    hp = 0;
    ro = 1'b1;
    measure("stuck", 0);
    ro = 1'b0;
    hp = 4;
    measure("repulse", 100);
    // Abort a measurement mid-window and confirm it is discarded.
    start = 1'b1;
    n0 = nidx;
    win_hi = -1;
    step();
    start = 1'b0;
    while (nidx < n0 + S + 500) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_roen", ro_en, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_cnt", cnt, 0);
    step();
    check("mid_idle", busy, 0);
    measure("after_rst", 0);
    for (int r = 0; r < 2; r++) begin
      hp = $urandom_range(2, 9);
      repeat ($urandom_range(1, 20)) step();
      measure("rand", 0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
